// File: rtl/rv32_ctrl_pkg.sv
// rv32_ctrl_pkg: shared encodings for the multicycle RV32I control unit
package rv32_ctrl_pkg;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [2:0] IMM_U = 3'b000;
  localparam logic [2:0] IMM_I = 3'b001;
  localparam logic [2:0] IMM_S = 3'b010;
  localparam logic [2:0] IMM_B = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;
  localparam logic [1:0] SRC_A_RS1  = 2'b00;
  localparam logic [1:0] SRC_A_PC   = 2'b01;
  localparam logic [1:0] SRC_A_ZERO = 2'b10;
  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;
  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEM_ACCESS, S_WRITEBACK, S_TRAP
  } state_e;
  function automatic alu_op_e alu_func(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/branch_condition_eval.sv
// branch_condition_eval: funct3 x ALU compare flags -> branch taken
module branch_condition_eval (
  input  logic [2:0] funct3,
  input  logic       alu_zero,
  input  logic       alu_lt,
  output logic       taken
);
  // funct3[0] inverts the base condition; 010/011 are not branches
  always_comb taken = funct3[2] ? (alu_lt ^ funct3[0]) : (!funct3[1] && (alu_zero ^ funct3[0]));
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: fetch/decode/execute/memory/writeback sequencer for RV32I
module multicycle_control_unit
  import rv32_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction_register,
  input  logic        alu_zero,
  input  logic        alu_lt,
  input  logic        mem_ready,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic [2:0]  immediate_select,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [3:0]  alu_op,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        illegal_instr,
  output logic        bus_error
);
  localparam int CW = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT) : 1;
  state_e state, state_nx;
  logic [CW-1:0] cnt;
  logic [6:0] opcode;
  logic [2:0] funct3, imm_dec;
  logic alt, is_load, is_store, is_branch, is_jump, legal, mem_state, in_ex, timeout;
  logic taken, branch_taken, unused_ir;
  logic [1:0] ex_a, ex_b;
  alu_op_e ex_op, cmp_op;
  assign opcode    = instruction_register[6:0];
  assign funct3    = instruction_register[14:12];
  assign alt       = instruction_register[30];
  assign unused_ir = ^{instruction_register[31], instruction_register[29:15], instruction_register[11:7]};
  assign is_load   = opcode == OP_LOAD;
  assign is_store  = opcode == OP_STORE;
  assign is_branch = opcode == OP_BRANCH;
  assign is_jump   = opcode == OP_JAL || opcode == OP_JALR;
  assign legal     = opcode inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG};
  assign mem_state = state == S_FETCH || state == S_MEM_ACCESS;
  assign in_ex     = state inside {S_EXECUTE, S_MEM_ACCESS, S_WRITEBACK};
  assign timeout   = MEM_TIMEOUT != 0 && mem_state && !mem_ready && cnt == CW'(MEM_TIMEOUT - 1);
  assign imm_dec   = (opcode == OP_LUI || opcode == OP_AUIPC) ? IMM_U :
                     is_store ? IMM_S : is_branch ? IMM_B : opcode == OP_JAL ? IMM_J : IMM_I;
  assign ex_a      = opcode == OP_LUI ? SRC_A_ZERO :
                     (opcode inside {OP_AUIPC, OP_JAL, OP_BRANCH}) ? SRC_A_PC : SRC_A_RS1;
  assign ex_b      = opcode == OP_REG ? SRC_B_RS2 : SRC_B_IMM;
  // only the shift-right immediate honours bit 30; ADDI has no subtract form
  assign ex_op     = opcode == OP_REG ? alu_func(funct3, alt) :
                     opcode == OP_IMM ? alu_func(funct3, funct3 == 3'b101 && alt) : ALU_ADD;
  assign cmp_op    = funct3[2] ? (funct3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
  branch_condition_eval u_bce (
    .funct3  (funct3),
    .alu_zero(alu_zero),
    .alu_lt  (alu_lt),
    .taken   (taken)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state         <= S_FETCH;
      cnt           <= '0;
      branch_taken  <= 1'b0;
      illegal_instr <= 1'b0;
      bus_error     <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= state_nx != state ? '0 : (mem_state && !mem_ready ? cnt + CW'(1) : cnt);
      if (state == S_DECODE) branch_taken <= taken;
      if (state == S_DECODE && !legal) illegal_instr <= 1'b1;
      if (timeout) bus_error <= 1'b1;
    end
  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH:      state_nx = timeout ? S_TRAP : mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:     state_nx = legal ? S_EXECUTE : S_TRAP;
      S_EXECUTE:    state_nx = (is_load || is_store) ? S_MEM_ACCESS : is_branch ? S_FETCH : S_WRITEBACK;
      S_MEM_ACCESS: state_nx = timeout ? S_TRAP : !mem_ready ? S_MEM_ACCESS : is_store ? S_FETCH : S_WRITEBACK;
      S_WRITEBACK:  state_nx = S_FETCH;
      default:      state_nx = S_TRAP;
    endcase
  end
  // reset forces FETCH asynchronously, so only the FETCH enables need rst_n gating
  always_comb begin
    ir_write         = rst_n && state == S_FETCH && mem_ready;
    mem_req          = rst_n && mem_state;
    mem_addr_sel     = state == S_MEM_ACCESS;
    mem_we           = state == S_MEM_ACCESS && is_store;
    pc_write         = (state == S_EXECUTE && is_branch) || (state == S_MEM_ACCESS && is_store && mem_ready) ||
                       state == S_WRITEBACK;
    pc_src           = (state == S_EXECUTE && is_branch && branch_taken) || (state == S_WRITEBACK && is_jump);
    reg_write        = state == S_WRITEBACK;
    wb_sel           = state != S_WRITEBACK ? WB_ALU : is_load ? WB_MEM : is_jump ? WB_PC4 : WB_ALU;
    immediate_select = (state == S_FETCH || state == S_TRAP) ? IMM_I : imm_dec;
    alu_src_a        = in_ex ? ex_a : SRC_A_RS1;
    alu_src_b        = in_ex ? ex_b : SRC_B_RS2;
    alu_op           = in_ex ? ex_op : state == S_DECODE ? cmp_op : ALU_ADD;
  end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: vector table, directed corners and random run against a phase model
module tb_multicycle_control_unit;
  import rv32_ctrl_pkg::*;
  localparam int TO = 16;
  localparam logic [31:0] ADDI = 32'h00500093, BEQ = 32'h00000463, SW = 32'h00112223;
  localparam logic [31:0] JAL = 32'h008000EF, LW = 32'h00002083, BAD = 32'h0000007F;
  localparam int C_R = 0, C_I = 1, C_LD = 2, C_ST = 3, C_BR = 4, C_JAL = 5, C_JALR = 6, C_LUI = 7, C_AUIPC = 8;
  logic clk = 0, rst_n = 0, alu_zero = 0, alu_lt = 0, mem_ready = 0;
  logic [31:0] instruction_register = '0;
  logic ir_write, pc_write, pc_src, mem_req, mem_we, mem_addr_sel, reg_write, illegal_instr, bus_error;
  logic [2:0] immediate_select;
  logic [1:0] alu_src_a, alu_src_b, wb_sel;
  logic [3:0] alu_op;
  typedef struct packed {
    logic irw, pcw, pcs;
    logic [2:0] imm;
    logic [1:0] a, b;
    logic [3:0] op;
    logic req, we, asel, rw;
    logic [1:0] wb;
    logic ill, berr;
  } outs_t;
  typedef struct {
    logic rst;
    logic [31:0] ir;
    logic rdy, z;
    outs_t e;
  } vec_t;
  outs_t got, F, RST, TRP;
  vec_t vt[$];
  int errors = 0, checks = 0;
  int ph = 0, w = 0;
  bit ill_m = 0, berr_m = 0, tk = 0;
  logic [31:0] next_instr = '0, ra, rb;
  assign got = {ir_write, pc_write, pc_src, immediate_select, alu_src_a, alu_src_b, alu_op,
                mem_req, mem_we, mem_addr_sel, reg_write, wb_sel, illegal_instr, bus_error};
  multicycle_control_unit #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .instruction_register(instruction_register),
    .alu_zero(alu_zero), .alu_lt(alu_lt), .mem_ready(mem_ready),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .immediate_select(immediate_select), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .reg_write(reg_write), .wb_sel(wb_sel), .illegal_instr(illegal_instr), .bus_error(bus_error)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic outs_t o(input int irw, pcw, pcs, imm, a, b, op, req, we, asel, rw, wb, ill = 0);
    outs_t r;
    r = '0;
    r.irw = irw[0]; r.pcw = pcw[0]; r.pcs = pcs[0]; r.imm = imm[2:0];
    r.a = a[1:0]; r.b = b[1:0]; r.op = op[3:0];
    r.req = req[0]; r.we = we[0]; r.asel = asel[0]; r.rw = rw[0]; r.wb = wb[1:0]; r.ill = ill[0];
    return r;
  endfunction
  task automatic addv(input logic rst, input logic [31:0] ir, input logic rdy, z, input outs_t e);
    vec_t v;
    v.rst = rst; v.ir = ir; v.rdy = rdy; v.z = z; v.e = e;
    vt.push_back(v);
  endtask
  function automatic int cls(input logic [6:0] op);
    case (op)
      7'h33: return C_R;
      7'h13: return C_I;
      7'h03: return C_LD;
      7'h23: return C_ST;
      7'h63: return C_BR;
      7'h6F: return C_JAL;
      7'h67: return C_JALR;
      7'h37: return C_LUI;
      7'h17: return C_AUIPC;
      default: return -1;
    endcase
  endfunction
  function automatic logic [2:0] imm_of(input int c);
    if (c == C_LUI || c == C_AUIPC) return 3'b000;
    if (c == C_ST) return 3'b010;
    if (c == C_BR) return 3'b011;
    if (c == C_JAL) return 3'b100;
    return 3'b001;
  endfunction
  function automatic logic [3:0] rop(input logic [2:0] f3, input logic sub);
    case (f3)
      3'd0: return sub ? ALU_SUB : ALU_ADD;
      3'd1: return ALU_SLL;
      3'd2: return ALU_SLT;
      3'd3: return ALU_SLTU;
      3'd4: return ALU_XOR;
      3'd5: return sub ? ALU_SRA : ALU_SRL;
      3'd6: return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
  function automatic bit taken_ref(input logic [2:0] f3, input logic [31:0] a, b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction
  function automatic outs_t model_out(input bit rdy);
    outs_t e;
    int c;
    logic [2:0] f3;
    c = cls(instruction_register[6:0]);
    f3 = instruction_register[14:12];
    e = '0;
    e.imm = 3'b001; e.ill = ill_m; e.berr = berr_m;
    if (ph == 0) begin
      e.req = 1'b1; e.irw = rdy;
    end else if (ph == 1) begin
      e.imm = imm_of(c);
      e.op = f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
    end else if (ph != 5) begin
      e.imm = imm_of(c);
      e.a = c == C_LUI ? 2'd2 : (c == C_AUIPC || c == C_JAL || c == C_BR) ? 2'd1 : 2'd0;
      e.b = c == C_R ? 2'd0 : 2'd1;
      e.op = c == C_R ? rop(f3, instruction_register[30]) :
             c == C_I ? rop(f3, f3 == 3'd5 && instruction_register[30]) : ALU_ADD;
      if (ph == 2 && c == C_BR) begin
        e.pcw = 1'b1; e.pcs = tk;
      end
      if (ph == 3) begin
        e.req = 1'b1; e.asel = 1'b1; e.we = c == C_ST; e.pcw = c == C_ST && rdy;
      end
      if (ph == 4) begin
        e.rw = 1'b1; e.pcw = 1'b1; e.pcs = c == C_JAL || c == C_JALR;
        e.wb = c == C_LD ? 2'd1 : (c == C_JAL || c == C_JALR) ? 2'd2 : 2'd0;
      end
    end
    return e;
  endfunction
  task automatic advance(input bit rdy, input logic [31:0] a, b);
    int np, c;
    np = ph;
    c = cls(instruction_register[6:0]);
    case (ph)
      0, 3: if (rdy) np = ph == 0 ? 1 : (c == C_ST ? 0 : 4);
            else if (++w == TO) begin np = 5; berr_m = 1; end
      1: begin
        tk = taken_ref(instruction_register[14:12], a, b);
        if (c < 0) begin np = 5; ill_m = 1; end else np = 2;
      end
      2: np = (c == C_LD || c == C_ST) ? 3 : c == C_BR ? 0 : 4;
      4: np = 0;
      default: np = 5;
    endcase
    if (np != ph) w = 0;
    ph = np;
  endtask
  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 20);
    r[6:0] = k == 20 ? 7'h73 : ops[k % 9];
    if (r[6:0] == 7'h63 && r[14:13] == 2'b01) r[13] = 1'b0;
    return r;
  endfunction
  task automatic cycle(input bit rdy, input logic [31:0] a, b);
    outs_t e;
    logic [2:0] f3;
    @(negedge clk);
    rst_n = 1;
    if (ph == 1) begin
      instruction_register = next_instr;
      next_instr = rand_instr();
    end
    f3 = instruction_register[14:12];
    alu_zero = a == b;
    alu_lt = f3[1] ? a < b : $signed(a) < $signed(b);
    mem_ready = rdy;
    #1;
    e = model_out(rdy);
    check($sformatf("model ph%0d ir=%h rdy=%0d", ph, instruction_register, rdy), 32'(got), 32'(e));
    advance(rdy, a, b);
  endtask
  task automatic model_reset();
    ph = 0; w = 0; ill_m = 0; berr_m = 0; tk = 0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    mem_ready = 1;
    #1;
    check("reset", 32'(got), 32'(RST));
    model_reset();
  endtask
  initial begin
    F = o(1, 0, 0, 1, 0, 0, ALU_ADD, 1, 0, 0, 0, 0);
    RST = o(0, 0, 0, 1, 0, 0, ALU_ADD, 0, 0, 0, 0, 0);
    TRP = o(0, 0, 0, 1, 0, 0, ALU_ADD, 0, 0, 0, 0, 0, 1);
    addv(0, 0, 1, 0, RST);
    addv(1, 0, 1, 0, F);
    addv(1, ADDI, 1, 0, o(0, 0, 0, 1, 0, 0, ALU_SUB, 0, 0, 0, 0, 0));
    addv(1, ADDI, 1, 0, o(0, 0, 0, 1, 0, 1, ALU_ADD, 0, 0, 0, 0, 0));
    addv(1, ADDI, 1, 0, o(0, 1, 0, 1, 0, 1, ALU_ADD, 0, 0, 0, 1, 0));
    addv(1, ADDI, 1, 0, F);
    addv(1, BEQ, 1, 1, o(0, 0, 0, 3, 0, 0, ALU_SUB, 0, 0, 0, 0, 0));
    addv(1, BEQ, 0, 0, o(0, 1, 1, 3, 1, 1, ALU_ADD, 0, 0, 0, 0, 0));
    addv(1, BEQ, 1, 0, F);
    addv(1, BEQ, 1, 0, o(0, 0, 0, 3, 0, 0, ALU_SUB, 0, 0, 0, 0, 0));
    addv(1, BEQ, 1, 1, o(0, 1, 0, 3, 1, 1, ALU_ADD, 0, 0, 0, 0, 0));
    addv(1, BEQ, 1, 0, F);
    addv(1, SW, 1, 0, o(0, 0, 0, 2, 0, 0, ALU_SUB, 0, 0, 0, 0, 0));
    addv(1, SW, 1, 0, o(0, 0, 0, 2, 0, 1, ALU_ADD, 0, 0, 0, 0, 0));
    addv(1, SW, 0, 0, o(0, 0, 0, 2, 0, 1, ALU_ADD, 1, 1, 1, 0, 0));
    addv(1, SW, 1, 0, o(0, 1, 0, 2, 0, 1, ALU_ADD, 1, 1, 1, 0, 0));
    addv(1, SW, 1, 0, F);
    addv(1, JAL, 1, 0, o(0, 0, 0, 4, 0, 0, ALU_SUB, 0, 0, 0, 0, 0));
    addv(1, JAL, 1, 0, o(0, 0, 0, 4, 1, 1, ALU_ADD, 0, 0, 0, 0, 0));
    addv(1, JAL, 1, 0, o(0, 1, 1, 4, 1, 1, ALU_ADD, 0, 0, 0, 1, 2));
    addv(1, JAL, 1, 0, F);
    addv(1, LW, 1, 0, o(0, 0, 0, 1, 0, 0, ALU_SUB, 0, 0, 0, 0, 0));
    addv(1, LW, 1, 0, o(0, 0, 0, 1, 0, 1, ALU_ADD, 0, 0, 0, 0, 0));
    repeat (3) addv(1, LW, 0, 0, o(0, 0, 0, 1, 0, 1, ALU_ADD, 1, 0, 1, 0, 0));
    addv(1, LW, 1, 0, o(0, 0, 0, 1, 0, 1, ALU_ADD, 1, 0, 1, 0, 0));
    addv(1, LW, 1, 0, o(0, 1, 0, 1, 0, 1, ALU_ADD, 0, 0, 0, 1, 1));
    addv(1, LW, 1, 0, F);
    addv(1, BAD, 1, 0, o(0, 0, 0, 1, 0, 0, ALU_SUB, 0, 0, 0, 0, 0));
    addv(1, BAD, 1, 0, TRP);
    addv(1, BAD, 1, 0, TRP);
    addv(0, BAD, 1, 0, RST);
    foreach (vt[i]) begin
      @(negedge clk);
      rst_n = vt[i].rst;
      instruction_register = vt[i].ir;
      mem_ready = vt[i].rdy;
      alu_zero = vt[i].z;
      alu_lt = 0;
      #1;
      check($sformatf("vec%0d", i), 32'(got), 32'(vt[i].e));
    end
    model_reset();
    // fetch timeout: sixteen idle cycles trap with bus_error
    repeat (TO) cycle(0, 0, 1);
    cycle(1, 0, 1);
    check("bus_error_flag", 32'(bus_error), 32'd1);
    check("trap_no_req", 32'(mem_req), 32'd0);
    do_reset();
    // one short of the timeout still completes normally
    next_instr = ADDI;
    repeat (TO - 1) cycle(0, 0, 1);
    repeat (4) cycle(1, 0, 1);
    // asynchronous reset drops mem_req mid-access
    next_instr = LW;
    repeat (3) cycle(1, 0, 1);
    @(negedge clk);
    mem_ready = 0;
    #1;
    check("mid_access_req", 32'(mem_req), 32'd1);
    rst_n = 0;
    #1;
    check("async_reset_req", 32'(mem_req), 32'd0);
    check("async_reset_outs", 32'(got), 32'(RST));
    model_reset();
    next_instr = rand_instr();
    for (int n = 0; n < 2000; n++) begin
      if (ph == 5 && $urandom_range(0, 2) == 0) do_reset();
      else begin
        ra = $urandom;
        rb = $urandom_range(0, 2) == 0 ? ra : $urandom;
        cycle($urandom_range(0, 3) != 0, ra, rb);
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
